// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
//   loader_state_t : frame parser states
//   BYTES_PER_WORD : stream bytes packed into one instruction word
//   CNT_W          : width of the frame word count and the word index
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_W          = 16;

endpackage

// File: rtl/imem_word_packer.sv
// Packs big-endian stream bytes into 32-bit words.
//   clk, rst   : clock, synchronous active-high reset
//   clear      : drop any partial word and restart the byte count
//   byte_in    : stream byte
//   shift      : byte_in is taken this cycle
//   word_out   : assembled word (valid when word_done is high)
//   word_done  : this shift supplies the 4th byte of a word
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    input  logic        shift,
    output logic [31:0] word_out,
    output logic        word_done
);

    // Only the first three bytes need storage; the fourth is taken
    // straight from byte_in so the word is complete in the same cycle.
    logic [23:0] shreg_q, shreg_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (clear) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if (shift) begin
            shreg_d = {shreg_q[15:0], byte_in};
            cnt_d   = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign word_out  = {shreg_q, byte_in};
    assign word_done = shift && !clear && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader for the MIPS instruction memory. Parses a framed byte stream
// (16-bit word count, big-endian words, XOR checksum), writes each word to
// ADDR_BASE + 4*index and releases the core reset once the image verifies.
//   clk, rst              : clock, synchronous active-high reset
//   byte_valid/byte_data  : input byte stream, transfers on valid && ready
//   byte_ready            : loader accepts bytes (low once DONE or ERR)
//   mem_we/addr/wdata     : one-cycle instruction-memory write
//   cpu_rst               : core reset, released only in DONE
//   done / error          : sticky load result flags
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'd0,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        error
);

    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_WORDS);

    loader_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] widx_q, widx_d;
    logic [7:0]       csum_q, csum_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;

    logic             xfer;
    logic [CNT_W-1:0] n_full;
    logic [31:0]      word_out;
    logic             word_done;

    assign byte_ready = (state_q != DONE) && (state_q != ERR);
    assign xfer       = byte_valid && byte_ready;
    assign n_full     = {cnt_q[15:8], byte_data};

    // Packer is held clear outside DATA so every data phase starts on byte 0.
    imem_word_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_q != DATA),
        .byte_in  (byte_data),
        .shift    (xfer && (state_q == DATA)),
        .word_out (word_out),
        .word_done(word_done)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            HDR_HI: begin
                if (xfer) begin
                    cnt_d   = {byte_data, 8'h00};
                    csum_d  = csum_q ^ byte_data;
                    state_d = HDR_LO;
                end
            end
            HDR_LO: begin
                if (xfer) begin
                    cnt_d  = n_full;
                    csum_d = csum_q ^ byte_data;
                    if (n_full > MAX_N)       state_d = ERR;
                    else if (n_full == '0)    state_d = CSUM;
                    else                      state_d = DATA;
                end
            end
            DATA: begin
                if (xfer) csum_d = csum_q ^ byte_data;
                if (word_done) begin
                    we_d    = 1'b1;
                    addr_d  = ADDR_BASE + {14'd0, widx_q, 2'b00};
                    wdata_d = word_out;
                    widx_d  = widx_q + 1'b1;
                    // widx < N <= 65535, so widx+1 cannot wrap here
                    if (widx_d == cnt_q) state_d = CSUM;
                end
            end
            CSUM: begin
                if (xfer) state_d = (byte_data == csum_q) ? DONE : ERR;
            end
            DONE, ERR: ;
            default: state_d = ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HDR_HI;
            cnt_q   <= '0;
            widx_q  <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= ADDR_BASE;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_rst   = (state_q != DONE);
    assign done      = (state_q == DONE);
    assign error     = (state_q == ERR);

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam logic [31:0] ADDR_BASE = 32'd0;
    localparam int          MAX_WORDS = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;

    imem_loader #(.ADDR_BASE(ADDR_BASE), .MAX_WORDS(MAX_WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] img_q[$];
    logic [7:0]  frame_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    logic        prev_we = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Write monitor: collects every write, and a write strobe must never
    // last two cycles.
    always @(negedge clk) begin
        if (mem_we) begin
            got_q.push_back({mem_addr, mem_wdata});
            chk("we_single_cycle", {63'd0, prev_we}, 64'd0);
        end
        prev_we = mem_we;
    end

    // Reference model: frame bytes and expected writes straight from the
    // frame rules (count, big-endian words, XOR of all preceding bytes).
    task automatic build_frame();
        logic [15:0] n;
        logic [7:0]  x;
        n = 16'(img_q.size());
        frame_q.delete();
        exp_q.delete();
        frame_q.push_back(n[15:8]);
        frame_q.push_back(n[7:0]);
        foreach (img_q[i]) begin
            for (int b = 3; b >= 0; b--) frame_q.push_back(img_q[i][b*8 +: 8]);
            exp_q.push_back({ADDR_BASE + 32'(4 * i), img_q[i]});
        end
        x = 8'h00;
        foreach (frame_q[i]) x ^= frame_q[i];
        frame_q.push_back(x);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int g = 0;
        while (g < 20 && int'($urandom_range(99)) < gap_pct) begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            @(posedge clk); #1;
            g++;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        byte_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        got_q.delete();
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_write"}, got_q[i], exp_q[i]);
    endtask

    task automatic run_image(input string tag, input int gap_pct, input bit bad);
        build_frame();
        if (bad) frame_q[frame_q.size()-1] ^= 8'h01;
        for (int i = 0; i < frame_q.size() - 1; i++) send_byte(frame_q[i], gap_pct);
        chk({tag, "_done_before_csum"}, {63'd0, done}, 64'd0);
        chk({tag, "_cpu_rst_before_csum"}, {63'd0, cpu_rst}, 64'd1);
        send_byte(frame_q[frame_q.size()-1], gap_pct);
        chk({tag, "_done"}, {63'd0, done}, {63'd0, !bad});
        chk({tag, "_error"}, {63'd0, error}, {63'd0, bad});
        chk({tag, "_cpu_rst"}, {63'd0, cpu_rst}, {63'd0, bad});
        chk({tag, "_byte_ready"}, {63'd0, byte_ready}, 64'd0);
        check_writes(tag);
    endtask

    task automatic load_plan_image();
        img_q.delete();
        img_q.push_back(32'h0000_0800);
        img_q.push_back(32'h0000_0000);
        img_q.push_back(32'h0805_000A);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_byte_ready", {63'd0, byte_ready}, 64'd1);
        chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
        chk("rst_mem_addr", {32'd0, mem_addr}, {32'd0, ADDR_BASE});
        chk("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("rst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_error", {63'd0, error}, 64'd0);
        rst = 1'b0;
        got_q.delete();

        // 3-word image, back-to-back bytes
        load_plan_image();
        run_image("plan3", 0, 1'b0);

        // empty image
        do_reset();
        img_q.delete();
        run_image("empty", 0, 1'b0);

        // bad checksum
        do_reset();
        load_plan_image();
        run_image("badcsum", 0, 1'b1);

        // oversize count 257
        do_reset();
        exp_q.delete();
        send_byte(8'h01, 0);
        chk("oversize_error_after_hi", {63'd0, error}, 64'd0);
        send_byte(8'h01, 0);
        chk("oversize_error", {63'd0, error}, 64'd1);
        chk("oversize_byte_ready", {63'd0, byte_ready}, 64'd0);
        chk("oversize_cpu_rst", {63'd0, cpu_rst}, 64'd1);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0);
        check_writes("oversize");

        // gapped stream
        do_reset();
        load_plan_image();
        run_image("gapped", 50, 1'b0);

        // reset mid-load after one word written
        do_reset();
        load_plan_image();
        build_frame();
        for (int i = 0; i < 6; i++) send_byte(frame_q[i], 0);
        @(posedge clk); #1;
        chk("midrst_first_write_seen", 64'(got_q.size()), 64'd1);
        do_reset();
        chk("midrst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
        chk("midrst_byte_ready", {63'd0, byte_ready}, 64'd1);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_error", {63'd0, error}, 64'd0);
        chk("midrst_mem_addr", {32'd0, mem_addr}, {32'd0, ADDR_BASE});
        run_image("midrst_reload", 0, 1'b0);

        // randomized images, random gap density, occasional bad checksum
        for (int k = 0; k < 6; k++) begin
            int  n;
            bit  bad;
            do_reset();
            img_q.delete();
            n = int'($urandom_range(1, 9));
            for (int i = 0; i < n; i++) img_q.push_back($urandom);
            bad = ($urandom_range(3) == 0);
            run_image("random", int'($urandom_range(0, 60)), bad);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
